wb_arbiter: RTL and testbench

Round-robin Wishbone classic arbiter that shares one slave (the on-chip SRAM) between `num_masters` requesters, e.g. the copperv instruction and data buses. A master owns the slave for its whole `cyc` period. The arbiter multiplexes the granted master's request onto the slave port and routes `ack` back to that master only. Grant is registered, so arbitration adds one cycle of latency per new bus ownership.

---
 rtl/wb_arbiter_pkg.sv | 15 +
 rtl/wb_rr_grant.sv | 36 +++
 rtl/wb_arbiter.sv | 110 +++++++++++
 tb/tb_wb_arbiter.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/wb_arbiter_pkg.sv
// wb_arbiter_pkg: shared types and helpers for the Wishbone round-robin arbiter.
//   state_t   : arbiter FSM encoding (idle / bus owned by a master)
//   slice_lo  : low bit index of master idx's field inside a packed bus
package wb_arbiter_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  function automatic int slice_lo(input int idx, input int width);
    return idx * width;
  endfunction

endpackage

// File: rtl/wb_rr_grant.sv
// wb_rr_grant: combinational round-robin picker.
//   req   : one request bit per master
//   last  : index of the master that most recently owned the bus
//   grant : first requesting index scanning last+1, last+2, ... (wrapping)
//   valid : at least one request is pending
module wb_rr_grant #(
  parameter int num_masters = 2,
  parameter int grant_width = $clog2(num_masters)
) (
  input  logic [num_masters-1:0] req,
  input  logic [grant_width-1:0] last,
  output logic [grant_width-1:0] grant,
  output logic                   valid
);

  logic [grant_width-1:0] idx;
  logic                   found;

  // Walk the masters starting just after 'last'; the first hit wins, so
  // 'last' itself is examined only after everyone else.
  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 1; i <= num_masters; i++) begin
      idx = grant_width'((int'(last) + i) % num_masters);
      if (!found && req[idx]) begin
        grant = idx;
        found = 1'b1;
      end
    end
  end

  assign valid = |req;

endmodule

// File: rtl/wb_arbiter.sv
// wb_arbiter: round-robin Wishbone classic arbiter sharing one slave between
// num_masters requesters. A master owns the slave for its whole cyc period;
// grant is registered, so each new ownership costs one dead cycle.
//   clock, reset          : rising-edge clock, async active-high reset
//   m_adr/m_datwr/m_sel   : packed per-master request fields (master i at i*width)
//   m_we/m_stb/m_cyc      : per-master control
//   m_ack                 : per-master ack, one-hot or zero
//   m_datrd               : slave read data broadcast to all masters
//   s_*                   : slave-side Wishbone port
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int addr_width   = 32,
  parameter int data_width   = 32,
  parameter int strobe_width = data_width / 8,
  parameter int num_masters  = 2,
  parameter int grant_width  = $clog2(num_masters)
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic [num_masters*addr_width-1:0]   m_adr,
  input  logic [num_masters*data_width-1:0]   m_datwr,
  output logic [data_width-1:0]               m_datrd,
  input  logic [num_masters-1:0]              m_we,
  input  logic [num_masters-1:0]              m_stb,
  input  logic [num_masters-1:0]              m_cyc,
  input  logic [num_masters*strobe_width-1:0] m_sel,
  output logic [num_masters-1:0]              m_ack,
  output logic [addr_width-1:0]               s_adr,
  output logic [data_width-1:0]               s_datwr,
  output logic                                s_we,
  output logic [strobe_width-1:0]             s_sel,
  output logic                                s_stb,
  output logic                                s_cyc,
  input  logic [data_width-1:0]               s_datrd,
  input  logic                                s_ack
);

  state_t                 state, state_n;
  logic [grant_width-1:0] grant, grant_n;
  logic [grant_width-1:0] last,  last_n;
  logic [grant_width-1:0] rr_grant;
  logic                   rr_valid;

  wb_rr_grant #(
    .num_masters (num_masters),
    .grant_width (grant_width)
  ) u_rr (
    .req   (m_cyc),
    .last  (last),
    .grant (rr_grant),
    .valid (rr_valid)
  );

  // State register. last starts at the top index so master 0 wins first.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      grant <= '0;
      last  <= grant_width'(num_masters - 1);
    end else begin
      state <= state_n;
      grant <= grant_n;
      last  <= last_n;
    end
  end

  // Next state: only the granted master dropping cyc ends ownership.
  always_comb begin
    state_n = state;
    grant_n = grant;
    last_n  = last;
    case (state)
      ST_IDLE: begin
        if (rr_valid) begin
          grant_n = rr_grant;
          state_n = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (!m_cyc[grant]) begin
          state_n = ST_IDLE;
          last_n  = grant;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // Outputs. Data-path fields always follow the grant slice so they are
  // never X, even in IDLE; control is gated by BUSY and by reset so an
  // in-flight transfer is cut off the instant reset rises.
  always_comb begin
    s_adr   = m_adr  [slice_lo(int'(grant), addr_width)   +: addr_width];
    s_datwr = m_datwr[slice_lo(int'(grant), data_width)   +: data_width];
    s_sel   = m_sel  [slice_lo(int'(grant), strobe_width) +: strobe_width];
    s_we    = m_we[grant];
    s_cyc   = 1'b0;
    s_stb   = 1'b0;
    m_ack   = '0;
    if (state == ST_BUSY && !reset) begin
      s_cyc        = m_cyc[grant];
      s_stb        = m_stb[grant] & m_cyc[grant];
      m_ack[grant] = s_ack;
    end
  end

  assign m_datrd = s_datrd;

endmodule

// File: tb/tb_wb_arbiter.sv
module tb_wb_arbiter;
  localparam int NM = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  logic              clock = 1'b0;
  logic              reset;
  logic [NM*AW-1:0]  m_adr;
  logic [NM*DW-1:0]  m_datwr;
  logic [DW-1:0]     m_datrd;
  logic [NM-1:0]     m_we, m_stb, m_cyc, m_ack;
  logic [NM*SW-1:0]  m_sel;
  logic [AW-1:0]     s_adr;
  logic [DW-1:0]     s_datwr;
  logic              s_we, s_stb, s_cyc;
  logic [SW-1:0]     s_sel;
  logic [DW-1:0]     s_datrd;
  logic              s_ack;

  int checks = 0;
  int errors = 0;

  wb_arbiter #(
    .addr_width (AW), .data_width (DW), .strobe_width (SW), .num_masters (NM)
  ) dut (
    .clock (clock), .reset (reset),
    .m_adr (m_adr), .m_datwr (m_datwr), .m_datrd (m_datrd),
    .m_we (m_we), .m_stb (m_stb), .m_cyc (m_cyc), .m_sel (m_sel), .m_ack (m_ack),
    .s_adr (s_adr), .s_datwr (s_datwr), .s_we (s_we), .s_sel (s_sel),
    .s_stb (s_stb), .s_cyc (s_cyc), .s_datrd (s_datrd), .s_ack (s_ack)
  );

  always #5 clock = ~clock;

  // SRAM model: acks one cycle after stb, single-cycle classic handshake.
  bit [DW-1:0] mem [16];
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      s_ack   <= 1'b0;
      s_datrd <= '0;
    end else if (s_cyc && s_stb && !s_ack) begin
      if (s_we) mem[s_adr[5:2]] <= s_datwr;
      s_datrd <= mem[s_adr[5:2]];
      s_ack   <= 1'b1;
    end else begin
      s_ack <= 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_m(input int i, input logic cyc, input logic stb, input logic we,
                       input logic [AW-1:0] adr, input logic [DW-1:0] dat,
                       input logic [SW-1:0] sel);
    m_cyc[i] = cyc;
    m_stb[i] = stb;
    m_we[i]  = we;
    m_adr[i*AW +: AW]   = adr;
    m_datwr[i*DW +: DW] = dat;
    m_sel[i*SW +: SW]   = sel;
  endtask

  task automatic idle_all();
    m_cyc = '0; m_stb = '0; m_we = '0;
  endtask

  // Wait for ack on master i, bounded; drops its cyc/stb afterwards.
  task automatic wait_ack(input int i, input string tag, output logic [DW-1:0] rd);
    int n = 0;
    rd = '0;
    while (!m_ack[i] && n < 20) begin tick(); n++; end
    chk({tag, "_ack_seen"}, 64'(m_ack[i]), 64'd1);
    rd = m_datrd;
    m_cyc[i] = 1'b0;
    m_stb[i] = 1'b0;
  endtask

  initial begin
    logic [DW-1:0] rd;
    int served [$];
    int cnt, remaining0, remaining1, m1_acked, n;

    m_adr = '0; m_datwr = '0; m_sel = '0; idle_all();
    reset = 1'b1;
    #2;
    chk("rst_s_cyc", 64'(s_cyc), 64'd0);
    chk("rst_m_ack", 64'(m_ack), 64'd0);
    tick(); tick();
    reset = 1'b0;

    // 1: single read by master 0
    set_m(0, 1, 1, 0, 32'h10, 32'h0, 4'hF);
    tick();
    chk("t1_s_stb", 64'(s_stb), 64'd1);
    chk("t1_s_adr", 64'(s_adr), 64'h10);
    chk("t1_m_ack_early", 64'(m_ack), 64'd0);
    tick();
    chk("t1_m_ack", 64'(m_ack), 64'b01);
    idle_all();
    tick(); tick();

    // 2: simultaneous requests from reset-like state (last=0 now, so m1 first).
    //    Re-reset to start from last=num_masters-1 and expect m0 first.
    reset = 1'b1; tick(); reset = 1'b0;
    set_m(0, 1, 1, 0, 32'h20, 32'h0, 4'hF);
    set_m(1, 1, 1, 0, 32'h24, 32'h0, 4'hF);
    tick();
    chk("t2_first_adr", 64'(s_adr), 64'h20);
    tick();
    chk("t2_m0_ack", 64'(m_ack), 64'b01);
    set_m(0, 0, 0, 0, 32'h20, 32'h0, 4'hF);
    tick();
    chk("t2_dead_cyc", 64'(s_cyc), 64'd0);
    tick();
    chk("t2_m1_adr", 64'(s_adr), 64'h24);
    chk("t2_m1_stb", 64'(s_stb), 64'd1);
    tick();
    chk("t2_m1_ack", 64'(m_ack), 64'b10);
    idle_all();
    tick(); tick();

    // 3: both masters back-to-back, 4 transactions each -> strict alternation.
    //    last=1 after test 2, so master 0 is served first.
    remaining0 = 4; remaining1 = 4; n = 0;
    set_m(0, 1, 1, 0, 32'h30, 32'h0, 4'hF);
    set_m(1, 1, 1, 0, 32'h34, 32'h0, 4'hF);
    while ((remaining0 > 0 || remaining1 > 0) && n < 200) begin
      tick(); n++;
      for (int i = 0; i < NM; i++) begin
        if (m_ack[i]) begin
          served.push_back(i);
          if (i == 0) remaining0--; else remaining1--;
          m_cyc[i] = 1'b0; m_stb[i] = 1'b0;
        end else if (!m_cyc[i] && ((i == 0) ? remaining0 : remaining1) > 0) begin
          m_cyc[i] = 1'b1; m_stb[i] = 1'b1;
        end
      end
    end
    chk("t3_count", 64'(served.size()), 64'd8);
    for (int k = 0; k < served.size(); k++)
      chk($sformatf("t3_order%0d", k), 64'(served[k]), 64'(k % 2));
    idle_all();
    tick(); tick();

    // 4: m0 locks the bus for 3 transfers while m1 waits
    cnt = 0; m1_acked = 0; n = 0;
    set_m(0, 1, 1, 0, 32'h40, 32'h0, 4'hF);
    set_m(1, 1, 1, 0, 32'h44, 32'h0, 4'hF);
    while (cnt < 3 && n < 100) begin
      tick(); n++;
      if (m_ack[1]) m1_acked++;
      if (m_ack[0]) begin cnt++; m_stb[0] = 1'b0; end
      else m_stb[0] = 1'b1;
    end
    chk("t4_m0_acks", 64'(cnt), 64'd3);
    chk("t4_m1_locked_out", 64'(m1_acked), 64'd0);
    m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
    wait_ack(1, "t4_m1", rd);
    tick(); tick();

    // 5: m1 writes, m0 reads back
    set_m(1, 1, 1, 1, 32'h4, 32'hDEADBEEF, 4'hF);
    wait_ack(1, "t5_wr", rd);
    m_we[1] = 1'b0;
    tick();
    set_m(0, 1, 1, 0, 32'h4, 32'h0, 4'hF);
    wait_ack(0, "t5_rd", rd);
    chk("t5_rdata", 64'(rd), 64'hDEADBEEF);
    tick(); tick();

    // 6: async reset between stb and ack
    set_m(0, 1, 1, 0, 32'h8, 32'h0, 4'hF);
    tick();
    chk("t6_stb_before", 64'(s_stb), 64'd1);
    #1 reset = 1'b1;
    #1;
    chk("t6_rst_s_cyc", 64'(s_cyc), 64'd0);
    chk("t6_rst_s_stb", 64'(s_stb), 64'd0);
    chk("t6_rst_m_ack", 64'(m_ack), 64'd0);
    idle_all();
    tick();
    reset = 1'b0;
    // Both request after reset: m0 wins since last resets to 1.
    set_m(0, 1, 1, 0, 32'h50, 32'h0, 4'hF);
    set_m(1, 1, 1, 0, 32'h54, 32'h0, 4'hF);
    tick();
    chk("t6_both_m0_first", 64'(s_adr), 64'h50);
    idle_all();
    tick();
    reset = 1'b1; tick(); reset = 1'b0;
    // Only m1 requests: it wins while m0 is idle.
    set_m(1, 1, 1, 0, 32'h58, 32'h0, 4'hF);
    tick();
    chk("t6_m1_alone_adr", 64'(s_adr), 64'h58);
    chk("t6_m1_alone_stb", 64'(s_stb), 64'd1);
    tick();
    chk("t6_m1_alone_ack", 64'(m_ack), 64'b10);
    idle_all();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
